// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the synchronous and asynchronous FIFOs.
//   fifo_addr_width()  - RAM address width for a given depth
//   FIFO_*_MARGIN      - default distance of the almost-flags from the ends
//   fifo_status_t      - bundle of the status/error flags a FIFO reports
package fifo_pkg;

  localparam int FIFO_AFULL_MARGIN  = 4;
  localparam int FIFO_AEMPTY_MARGIN = 4;

  // A depth of 1 still needs one address bit to keep ports well formed.
  function automatic int fifo_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sdp_ram_1clk.sv
// sdp_ram_1clk: single-clock simple dual-port RAM, DATA_WIDTH x DEPTH.
//   clk             rising-edge clock for both ports
//   we/waddr/wdata  write port
//   re/raddr        read request and address
//   rdata           registered read data; holds when re=0
module sdp_ram_1clk
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 256,
  localparam int ADDR_WIDTH = fifo_addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto block RAM; every consumer
  // must only read locations it has previously written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO built around sdp_ram_1clk.
//   clk, rst          clock and synchronous active-high reset
//   wr_en, wr_data    write request and word (ignored while full)
//   rd_en             read request (ignored while empty)
//   rd_data, rd_valid popped word and its one-cycle strobe
//   full, empty, almost_full, almost_empty  registered occupancy flags
//   count             occupancy 0..DEPTH
//   overflow, underflow  sticky rejected-write / rejected-read flags
//   clr_err           clears the sticky flags (a same-cycle set wins)
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH    = 8,
  parameter  int DEPTH         = 256,
  parameter  int AFULL_THRESH  = DEPTH - FIFO_AFULL_MARGIN,
  parameter  int AEMPTY_THRESH = FIFO_AEMPTY_MARGIN,
  localparam int ADDR_WIDTH    = fifo_addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_LVL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_LVL  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_LVL = CNT_W'(AEMPTY_THRESH);

  localparam fifo_status_t STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  // Reject unusable configurations at elaboration rather than in silicon.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_ctrl: DEPTH must be a power of two and >= 4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_ctrl: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_ctrl: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  // Pointers carry one extra bit and wrap modulo 2*DEPTH; the low bits
  // index the RAM.
  logic [CNT_W-1:0]      wr_ptr_q;
  logic [CNT_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_next;
  fifo_status_t          status_q;
  logic                  rd_valid_q;
  logic                  rd_data_live_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic wr_acc;
  logic rd_acc;
  logic ovf_set;
  logic unf_set;

  // Acceptance uses the registered flags only, so a full FIFO never writes
  // through and an empty FIFO never bypasses, even with the other port
  // active. This also keeps both ports off the same RAM address.
  assign wr_acc  = wr_en & ~status_q.full;
  assign rd_acc  = rd_en & ~status_q.empty;
  assign ovf_set = wr_en &  status_q.full;
  assign unf_set = rd_en &  status_q.empty;

  // NOTE: every variable written in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + ONE;
      2'b01:   count_next = count_q - ONE;
      default: count_next = count_q;
    endcase
  end

  sdp_ram_1clk #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      status_q       <= STATUS_RST;
      rd_valid_q     <= 1'b0;
      rd_data_live_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + ONE;
      end
      if (rd_acc) begin
        rd_ptr_q       <= rd_ptr_q + ONE;
        rd_data_live_q <= 1'b1;
      end
      rd_valid_q <= rd_acc;
      count_q    <= count_next;

      status_q.full         <= (count_next == DEPTH_LVL);
      status_q.empty        <= (count_next == '0);
      status_q.almost_full  <= (count_next >= AFULL_LVL);
      status_q.almost_empty <= (count_next <= AEMPTY_LVL);

      if (ovf_set) begin
        status_q.overflow <= 1'b1;
      end else if (clr_err) begin
        status_q.overflow <= 1'b0;
      end
      if (unf_set) begin
        status_q.underflow <= 1'b1;
      end else if (clr_err) begin
        status_q.underflow <= 1'b0;
      end
    end
  end

  // The RAM read register has no reset; rd_data reads as zero until the
  // first pop after reset, then shows (and holds) the last popped word.
  assign rd_data      = rd_data_live_q ? ram_rdata : '0;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: scoreboard bench for sync_fifo_ctrl with DEPTH=8,
// AFULL_THRESH=6, AEMPTY_THRESH=1. Accepted writes are queued; each popped
// word is compared against the head of the queue when rd_valid appears.
module tb_sync_fifo_ctrl;

  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int AEMPTY = 1;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;
  logic          clr_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_count;
  logic          m_rv;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] exp_q[$];

  sync_fifo_ctrl #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL),
    .AEMPTY_THRESH (AEMPTY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_count = 0;
    m_rv    = 1'b0;
    m_rdata = '0;
    exp_q.delete();
  endtask

  // One clock: drive the request, let the edge pass, advance the model and
  // compare the read strobe, read word and occupancy.
  task automatic cycle(input logic wr, input logic [DW-1:0] d,
                       input logic rd, input logic clr);
    logic w_acc, r_acc;
    w_acc   = wr && (m_count != DEPTH);
    r_acc   = rd && (m_count != 0);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    clr_err = clr;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    if (w_acc) exp_q.push_back(d);
    m_count = m_count + int'(w_acc) - int'(r_acc);
    m_rv    = r_acc;
    if (r_acc) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underrun: read with empty expected queue");
      end else begin
        m_rdata = exp_q.pop_front();
      end
    end
    total++;
    if (rd_valid !== m_rv) begin
      bad++;
      $display("FAIL rd_valid: got %b want %b", rd_valid, m_rv);
    end
    total++;
    if (rd_data !== m_rdata) begin
      bad++;
      $display("FAIL rd_data: got %h want %h", rd_data, m_rdata);
    end
    total++;
    if (count !== 4'(m_count)) begin
      bad++;
      $display("FAIL count: got %0d want %0d", count, m_count);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_flags: got e=%b ae=%b f=%b af=%b want 1 1 0 0",
               empty, almost_empty, full, almost_full);
    end
    total++;
    if ({overflow, underflow} !== 2'b00) begin
      bad++;
      $display("FAIL reset_errors: got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
    total++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_read: got data=%h valid=%b want 00 0", rd_data, rd_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      total++;
      if (almost_empty !== (i <= AEMPTY) || almost_full !== (i >= AFULL)) begin
        bad++;
        $display("FAIL fill_almost[%0d]: got ae=%b af=%b want %b %b",
                 i, almost_empty, almost_full, (i <= AEMPTY), (i >= AFULL));
      end
      total++;
      if (full !== (i == DEPTH) || empty !== 1'b0) begin
        bad++;
        $display("FAIL fill_full[%0d]: got f=%b e=%b want %b 0", i, full, empty, (i == DEPTH));
      end
    end
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b1 || full !== 1'b1 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL fill_overflow: got ovf=%b full=%b unf=%b want 1 1 0", overflow, full, underflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (empty !== (i == DEPTH) || almost_empty !== ((DEPTH - i) <= AEMPTY)) begin
        bad++;
        $display("FAIL drain_flags[%0d]: got e=%b ae=%b want %b %b",
                 i, empty, almost_empty, (i == DEPTH), ((DEPTH - i) <= AEMPTY));
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (underflow !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL drain_underflow: got unf=%b ovf=%b want 1 1", underflow, overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    total++;
    if (underflow !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL drain_clear: got unf=%b ovf=%b want 0 0", underflow, overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    // 24 writes in total through 8 entries: the RAM index wraps three times.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
      total++;
      if (count !== 4'd4 || almost_empty !== 1'b0 || almost_full !== 1'b0) begin
        bad++;
        $display("FAIL b2b_steady[%0d]: got count=%0d ae=%b af=%b want 4 0 0",
                 i, count, almost_empty, almost_full);
      end
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (empty !== 1'b1 || exp_q.size() != 0 || rd_data !== 8'h33) begin
      bad++;
      $display("FAIL b2b_end: got empty=%b left=%0d last=%h want 1 0 33",
               empty, exp_q.size(), rd_data);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    total++;
    if (overflow !== 1'b1 || count !== 4'd7 || full !== 1'b0 || rd_data !== 8'h31) begin
      bad++;
      $display("FAIL full_rw: got ovf=%b count=%0d full=%b data=%h want 1 7 0 31",
               overflow, count, full, rd_data);
    end
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL set_beats_clr: got ovf=%b want 1", overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      bad++;
      $display("FAIL clr_only: got ovf=%b full=%b want 0 1", overflow, full);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (rd_data !== 8'h66 || empty !== 1'b1) begin
      bad++;
      $display("FAIL full_rw_drain: got data=%h empty=%b want 66 1", rd_data, empty);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 8'h61, 1'b0, 1'b0);
    cycle(1'b1, 8'h62, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // Reset lands with a read still requested; it must be ignored.
    rst   = 1'b1;
    rd_en = 1'b1;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    model_reset();
    total++;
    if (rd_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid: got valid=%b count=%0d empty=%b data=%h want 0 0 1 00",
               rd_valid, count, empty, rd_data);
    end
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (rd_data !== 8'h77 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_new: got data=%h valid=%b want 77 1", rd_data, rd_valid);
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_rw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
